// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state type and burst legality helpers
// for the instruction-memory responder.
package axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WAIT  = 2'b01,
      ST_BURST = 2'b10
   } state_e;

   // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

   // A request that can never be served: every beat answers SLVERR.
   function automatic logic ar_illegal(input logic [1:0] burst,
                                       input logic [2:0] size,
                                       input logic [7:0] len);
      logic w_bad_size;
      w_bad_size = (size != 3'd2) && (size != 3'd3);
      return (burst == BURST_RSVD) || w_bad_size ||
             ((burst == BURST_WRAP) && !wrap_len_ok(len));
   endfunction

endpackage

// File: rtl/axi_imem_responder_if.sv
// Read-address and read-data channels between the fetch initiator
// (master) and the instruction-memory responder (slave).
interface axi_imem_responder_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;

   modport master (
      output araddr, arvalid, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );

   modport slave (
      input  araddr, arvalid, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast
   );
endinterface

// File: rtl/imem_array.sv
// Instruction storage with a combinational two-word read: the word at
// the beat address and the one after it, each with an in-range flag.
// Out-of-range words read as zero.
module imem_array #(
   parameter int    DEPTH_WORDS = 1024,
   parameter string INIT_FILE   = ""
) (
   input  logic [31:0] i_addr,
   output logic [31:0] o_lo,
   output logic [31:0] o_hi,
   output logic        o_lo_ok,
   output logic        o_hi_ok
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [31:0] BYTES = 32'(DEPTH_WORDS) << 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

   logic [31:0]      r_mem [DEPTH_WORDS];
   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] w_idx1;

   // Byte offset within the word is ignored: the beat is word addressed.
   always_comb begin
      w_idx   = i_addr[IDX_W+1:2];
      w_idx1  = w_idx + 1'b1;
      o_lo_ok = (i_addr < BYTES);
      o_hi_ok = o_lo_ok && (w_idx != LAST_IDX);
      o_lo    = o_lo_ok ? r_mem[w_idx]  : 32'd0;
      o_hi    = o_hi_ok ? r_mem[w_idx1] : 32'd0;
   end

endmodule

// File: rtl/axi_imem_responder.sv
// AXI4 read-only instruction memory responder. One burst in flight:
// IDLE accepts AR, WAIT burns READ_LATENCY cycles, BURST streams 64-bit
// beats with registered rdata/rresp/rlast and honours rready stalls.
module axi_imem_responder
   import axi_pkg::*;
#(
   parameter int    DEPTH_WORDS  = 1024,
   parameter int    READ_LATENCY = 0,
   parameter string INIT_FILE    = ""
) (
   input logic               clk,
   input logic               rst,
   axi_imem_responder_if.slave axi
);

   state_e      r_state;
   logic        r_arready;
   logic        r_rvalid;
   logic        r_rlast;
   logic [1:0]  r_rresp;
   logic [63:0] r_rdata;
   logic [31:0] r_addr;
   logic [7:0]  r_len;
   logic [7:0]  r_beat;
   logic [2:0]  r_size;
   logic [1:0]  r_burst;
   logic        r_err;
   logic [3:0]  r_lat;

   logic [31:0] w_bytes;
   logic [31:0] w_mask;
   logic [31:0] w_next_addr;
   logic [31:0] w_beat_addr;
   logic [31:0] w_lo;
   logic [31:0] w_hi;
   logic        w_lo_ok;
   logic        w_hi_ok;
   logic [63:0] w_data;
   logic [1:0]  w_resp;

   assign axi.arready = r_arready;
   assign axi.rvalid  = r_rvalid;
   assign axi.rlast   = r_rlast;
   assign axi.rresp   = r_rresp;
   assign axi.rdata   = r_rdata;

   // Next beat address; WRAP keeps the upper bits of the aligned window
   // and lets only the low bits roll over.
   always_comb begin
      w_bytes     = 32'd1 << r_size;
      w_mask      = ((32'(r_len) + 32'd1) << r_size) - 32'd1;
      w_next_addr = r_addr;
      case (r_burst)
         BURST_INCR: w_next_addr = r_addr + w_bytes;
         BURST_WRAP: w_next_addr = (r_addr & ~w_mask) | ((r_addr + w_bytes) & w_mask);
         default:    w_next_addr = r_addr;
      endcase
   end

   // While a beat is on the bus, look ahead to the next one so an
   // accepted beat is replaced on the following cycle without a bubble.
   assign w_beat_addr = r_rvalid ? w_next_addr : r_addr;

   imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INIT_FILE   (INIT_FILE)
   ) u_mem (
      .i_addr  (w_beat_addr),
      .o_lo    (w_lo),
      .o_hi    (w_hi),
      .o_lo_ok (w_lo_ok),
      .o_hi_ok (w_hi_ok)
   );

   // Beat response: illegal request beats a bad address, data zeroed on error.
   always_comb begin
      w_resp = RESP_OKAY;
      w_data = {w_hi, w_lo};
      if (r_err) begin
         w_resp = RESP_SLVERR;
         w_data = 64'd0;
      end else if (!w_lo_ok) begin
         w_resp = RESP_DECERR;
         w_data = 64'd0;
      end
   end

   // Control FSM with all bus outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= 64'd0;
         r_addr    <= 32'd0;
         r_len     <= 8'd0;
         r_beat    <= 8'd0;
         r_size    <= 3'd0;
         r_burst   <= 2'd0;
         r_err     <= 1'b0;
         r_lat     <= 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_arready <= 1'b1;
               if (r_arready && axi.arvalid) begin
                  r_arready <= 1'b0;
                  r_addr    <= axi.araddr;
                  r_len     <= axi.arlen;
                  r_size    <= axi.arsize;
                  r_burst   <= axi.arburst;
                  r_err     <= ar_illegal(axi.arburst, axi.arsize, axi.arlen);
                  r_beat    <= 8'd0;
                  r_lat     <= 4'(READ_LATENCY);
                  r_state   <= (READ_LATENCY == 0) ? ST_BURST : ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_lat <= r_lat - 4'd1;
               if (r_lat <= 4'd1) r_state <= ST_BURST;
            end
            ST_BURST: begin
               if (!r_rvalid) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= w_data;
                  r_rresp  <= w_resp;
                  r_rlast  <= (r_len == 8'd0);
               end else if (axi.rready) begin
                  if (r_rlast) begin
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_rresp   <= RESP_OKAY;
                     r_rdata   <= 64'd0;
                     r_arready <= 1'b1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_addr  <= w_next_addr;
                     r_beat  <= r_beat + 8'd1;
                     r_rdata <= w_data;
                     r_rresp <= w_resp;
                     r_rlast <= ((r_beat + 8'd1) == r_len);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_imem_responder.sv
// Scoreboard bench: dut0 has READ_LATENCY=0, dut1 has READ_LATENCY=3.
// Memory: word 0 = 0x00000013, word 1 = 0x00100093, word i = 0xC0DE0000|i.
module tb_axi_imem_responder;
   import axi_pkg::*;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_tot  = 0;

   logic [31:0] araddr  [2];
   logic [7:0]  arlen   [2];
   logic [2:0]  arsize  [2];
   logic [1:0]  arburst [2];
   logic [1:0]  arvalid;
   logic [1:0]  rready;
   logic [1:0]  arready_w, rvalid_w, rlast_w;
   logic [63:0] rdata_w [2];
   logic [1:0]  rresp_w [2];
   logic [1:0]  prev_rv, prev_rr, prev_last;
   logic [63:0] prev_data [2];
   logic [1:0]  prev_resp [2];

   beat_t q0[$];
   beat_t q1[$];
   int    lq0[$];
   int    lq1[$];

   axi_imem_responder_if if0 ();
   axi_imem_responder_if if1 ();

   assign if0.araddr = araddr[0];  assign if1.araddr = araddr[1];
   assign if0.arlen = arlen[0];    assign if1.arlen = arlen[1];
   assign if0.arsize = arsize[0];  assign if1.arsize = arsize[1];
   assign if0.arburst = arburst[0]; assign if1.arburst = arburst[1];
   assign if0.arvalid = arvalid[0]; assign if1.arvalid = arvalid[1];
   assign if0.rready = rready[0];  assign if1.rready = rready[1];
   assign arready_w = {if1.arready, if0.arready};
   assign rvalid_w  = {if1.rvalid, if0.rvalid};
   assign rlast_w   = {if1.rlast, if0.rlast};
   assign rdata_w[0] = if0.rdata;  assign rdata_w[1] = if1.rdata;
   assign rresp_w[0] = if0.rresp;  assign rresp_w[1] = if1.rresp;

   axi_imem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(0), .INIT_FILE("")) u0 (
      .clk (clk), .rst (rst), .axi (if0.slave));
   axi_imem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(3), .INIT_FILE("")) u1 (
      .clk (clk), .rst (rst), .axi (if1.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic exp_beat(input int d, input logic [63:0] data, input logic [1:0] resp,
                           input logic last);
      beat_t b;
      b = '{data: data, resp: resp, last: last};
      if (d == 0) q0.push_back(b);
      else q1.push_back(b);
   endtask

   // Monitor for one DUT: first-beat latency, stall stability, beat contents.
   task automatic mon(input int d);
      beat_t e, a;
      int    ec;
      logic  have;
      a = '{data: rdata_w[d], resp: rresp_w[d], last: rlast_w[d]};
      if (rvalid_w[d] && !prev_rv[d]) begin
         have = 1'b0;
         ec   = 0;
         if (d == 0 && lq0.size() > 0) begin ec = lq0.pop_front(); have = 1'b1; end
         if (d == 1 && lq1.size() > 0) begin ec = lq1.pop_front(); have = 1'b1; end
         if (have) chk($sformatf("dut%0d_first_rvalid_cycle", d), 96'(cyc), 96'(ec));
      end
      if (prev_rv[d] && !prev_rr[d] && rvalid_w[d])
         chk($sformatf("dut%0d_stall_hold", d), 96'(a),
             96'({prev_data[d], prev_resp[d], prev_last[d]}));
      if (rvalid_w[d] && rready[d]) begin
         have = 1'b0;
         e    = '0;
         if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         if (have) chk($sformatf("dut%0d_beat", d), 96'(a), 96'(e));
         else chk($sformatf("dut%0d_unexpected_beat", d), 96'(rvalid_w[d]), 96'd0);
      end
      prev_rv[d]   = rvalid_w[d];
      prev_rr[d]   = rready[d];
      prev_last[d] = rlast_w[d];
      prev_data[d] = rdata_w[d];
      prev_resp[d] = rresp_w[d];
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   // Issue one AR; returns just after the handshake edge.
   task automatic do_ar(input int d, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      @(negedge clk);
      araddr[d] = a; arlen[d] = len; arsize[d] = size; arburst[d] = burst;
      arvalid[d] = 1'b1;
      while (!arready_w[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk($sformatf("dut%0d_ar_timeout", d), 96'(arready_w[d]), 96'd1);
      if (d == 0) lq0.push_back(cyc + 2);
      else lq1.push_back(cyc + 2 + 3);
      @(posedge clk);
      #1 arvalid[d] = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int n = 0;
      while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         n_tot++;
         $display("FAIL dut%0d_burst_timeout: got %0d beats pending want 0", d,
                  (d == 0) ? q0.size() : q1.size());
         q0.delete(); q1.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rvalid(input int d);
      int n = 0;
      while (!rvalid_w[d] && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) chk($sformatf("dut%0d_rvalid_timeout", d), 96'(rvalid_w[d]), 96'd1);
   endtask

   task automatic chk_reset_outs(input string nm);
      for (int d = 0; d < 2; d++)
         chk($sformatf("%s_dut%0d", nm, d),
             96'({arready_w[d], rvalid_w[d], rlast_w[d], rresp_w[d], rdata_w[d]}), 96'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         u0.u_mem.r_mem[i] = (i == 0) ? 32'h00000013 :
                             (i == 1) ? 32'h00100093 : (32'hC0DE0000 | 32'(i));
         u1.u_mem.r_mem[i] = u0.u_mem.r_mem[i];
      end
      prev_rv = '0; prev_rr = '0; prev_last = '0;
      for (int d = 0; d < 2; d++) begin
         araddr[d] = '0; arlen[d] = '0; arsize[d] = '0; arburst[d] = '0;
         prev_data[d] = '0; prev_resp[d] = '0;
      end
      arvalid = '0;
      rready  = 2'b11;

      // Reset values and arready release
      repeat (3) @(negedge clk);
      chk_reset_outs("reset_outs");
      rst = 1'b0;
      #1 chk("arready_low_at_release", 96'(arready_w), 96'd0);
      @(negedge clk);
      chk("arready_first_edge", 96'(arready_w), 96'b11);

      // Single beat, latency 0, then arready back one cycle after the beat
      exp_beat(0, 64'h00100093_00000013, RESP_OKAY, 1'b1);
      do_ar(0, 32'h0, 8'd0, 3'd2, BURST_INCR);
      @(negedge clk);
      @(negedge clk);
      chk("single_rvalid", 96'(rvalid_w[0]), 96'd1);
      @(negedge clk);
      chk("single_arready_back", 96'({arready_w[0], rvalid_w[0]}), 96'b10);
      wait_done(0);

      // WRAP 0x38 len 3 size 3: 0x38, 0x20, 0x28, 0x30
      exp_beat(0, 64'hC0DE000F_C0DE000E, RESP_OKAY, 1'b0);
      exp_beat(0, 64'hC0DE0009_C0DE0008, RESP_OKAY, 1'b0);
      exp_beat(0, 64'hC0DE000B_C0DE000A, RESP_OKAY, 1'b0);
      exp_beat(0, 64'hC0DE000D_C0DE000C, RESP_OKAY, 1'b1);
      do_ar(0, 32'h38, 8'd3, 3'd3, BURST_WRAP);
      wait_done(0);

      // WRAP with 3 beats is illegal
      exp_beat(0, 64'd0, RESP_SLVERR, 1'b0);
      exp_beat(0, 64'd0, RESP_SLVERR, 1'b0);
      exp_beat(0, 64'd0, RESP_SLVERR, 1'b1);
      do_ar(0, 32'h40, 8'd2, 3'd3, BURST_WRAP);
      wait_done(0);

      // Top of memory: high half out of range, then fully out of range
      exp_beat(0, 64'h00000000_C0DE03FF, RESP_OKAY, 1'b1);
      do_ar(0, 32'hFFC, 8'd0, 3'd2, BURST_INCR);
      wait_done(0);
      exp_beat(0, 64'd0, RESP_DECERR, 1'b1);
      do_ar(0, 32'h1000, 8'd0, 3'd2, BURST_INCR);
      wait_done(0);

      // FIXED holds the address
      exp_beat(0, 64'hC0DE0003_C0DE0002, RESP_OKAY, 1'b0);
      exp_beat(0, 64'hC0DE0003_C0DE0002, RESP_OKAY, 1'b1);
      do_ar(0, 32'h8, 8'd1, 3'd2, BURST_FIXED);
      wait_done(0);

      // Illegal size and reserved burst
      exp_beat(0, 64'd0, RESP_SLVERR, 1'b1);
      do_ar(0, 32'h0, 8'd0, 3'd1, BURST_INCR);
      wait_done(0);
      exp_beat(0, 64'd0, RESP_SLVERR, 1'b0);
      exp_beat(0, 64'd0, RESP_SLVERR, 1'b1);
      do_ar(0, 32'h0, 8'd1, 3'd2, BURST_RSVD);
      wait_done(0);

      // INCR running off the end of memory
      exp_beat(0, 64'hC0DE03FF_C0DE03FE, RESP_OKAY, 1'b0);
      exp_beat(0, 64'd0, RESP_DECERR, 1'b1);
      do_ar(0, 32'hFF8, 8'd1, 3'd3, BURST_INCR);
      wait_done(0);

      // Latency 3, INCR 0x10 len 3 size 3, first beat stalled two cycles
      exp_beat(1, 64'hC0DE0005_C0DE0004, RESP_OKAY, 1'b0);
      exp_beat(1, 64'hC0DE0007_C0DE0006, RESP_OKAY, 1'b0);
      exp_beat(1, 64'hC0DE0009_C0DE0008, RESP_OKAY, 1'b0);
      exp_beat(1, 64'hC0DE000B_C0DE000A, RESP_OKAY, 1'b1);
      rready[1] = 1'b0;
      do_ar(1, 32'h10, 8'd3, 3'd3, BURST_INCR);
      wait_rvalid(1);
      repeat (2) @(posedge clk);
      #1 rready[1] = 1'b1;
      wait_done(1);

      // Reset during beat 2 of a 4-beat burst
      exp_beat(1, 64'h00100093_00000013, RESP_OKAY, 1'b0);
      do_ar(1, 32'h0, 8'd3, 3'd3, BURST_INCR);
      wait_rvalid(1);
      @(posedge clk);
      #1 chk("beat2_before_reset", 96'({rvalid_w[1], rlast_w[1]}), 96'b10);
      rst = 1'b1;
      #1 chk_reset_outs("midburst_reset_outs");
      q0.delete(); q1.delete(); lq0.delete(); lq1.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_beat(1, 64'h00100093_00000013, RESP_OKAY, 1'b1);
      do_ar(1, 32'h0, 8'd0, 3'd2, BURST_INCR);
      wait_done(1);
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
